gcd_sched: RTL
==============

# gcd_sched

Round-robin scheduler that shares one `gcd` unit among `NREQ` independent requesters. It accepts operand pairs over per-requester valid/ready handshakes and sequences the shared unit's `start`/`done` protocol. It returns each result on a per-requester response handshake. It sits between the client blocks and the single `gcd` instance and is the only driver of that instance's `start`, `a_in` and `b_in`.

## Interface
- `NREQ`, 4: number of requesters, 2..8
- `WIDTH`, 32: operand/result width
- `TIMEOUT`, 1024: watchdog limit in cycles (used only with `GCD_SCHED_TIMEOUT_EN`)

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `reset` in 1: synchronous, active-high
- `req_valid` in NREQ: requester i has an operand pair
- `req_ready` out NREQ: one-hot accept strobe
- `req_a`, `req_b` in NREQ×WIDTH: per-requester operands
- `rsp_valid` out NREQ: one-hot, result pending for requester i
- `rsp_ready` in NREQ: requester i consumes its result
- `rsp_result` out WIDTH: result, shared bus, valid with `rsp_valid`
- `rsp_err` out 1: result is a timeout, not a GCD (0 when macro off)
- `gcd_start` out 1: one-cycle start pulse to the gcd unit
- `gcd_a`, `gcd_b` out WIDTH: operands to the gcd unit, held stable from launch until done
- `gcd_done` in 1: gcd unit completion
- `gcd_result` in WIDTH: gcd unit result, sampled when `gcd_done`=1

## Operation
- FSM states are IDLE, LAUNCH, WAIT, RESP. Reset enters IDLE.
- IDLE:
  - Grant the first i with `req_valid[i]`=1, searching from `ptr` upward modulo NREQ.
  - Assert `req_ready[i]` in the same cycle, combinationally from `req_valid`. Latch `req_a[i]`/`req_b[i]` into `gcd_a`/`gcd_b` and latch the grant index.
  - Go to LAUNCH.
  - With no request, stay in IDLE.
- LAUNCH: `gcd_start`=1 for exactly this cycle; `gcd_done` is ignored; go to WAIT.
- WAIT: on `gcd_done`=1, latch `gcd_result` into `rsp_result`, clear `rsp_err`, and go to RESP.
- RESP:
  - Hold `rsp_valid[g]`=1 and `rsp_result` stable until `rsp_ready[g]`=1.
  - In that cycle, set `ptr` to (g+1) mod NREQ and go to IDLE.
  - `rsp_ready` of non-granted requesters is ignored.
- Only one operation is in flight. `req_ready` is 0 outside IDLE.
- Operands pass through unmodified, including zeros; the gcd unit defines gcd(x,0).
- Reset mid-operation:
  - Abandon the operation; no response is issued.
  - `ptr` goes to 0 and all outputs return to reset values.
  - The gcd unit is reset by its own reset.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_result`=0, `rsp_err`=0, `gcd_start`=0, `gcd_a`=0, `gcd_b`=0, `ptr`=0.
- Accept (cycle 0) → `gcd_start` (cycle 1) → earliest `gcd_done` sampled (cycle 2) → `rsp_valid` (cycle 3).
- Total latency is 3 cycles plus the gcd compute time.
- If `rsp_ready` is already high, `rsp_valid` lasts 1 cycle. The next accept is possible in the cycle after the RESP exit.
- Fairness: a continuously requesting requester is served within NREQ operations.
- `gcd_a`/`gcd_b` change only in the IDLE accept cycle.

## Configuration
- `GCD_SCHED_TIMEOUT_EN` defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - At `TIMEOUT` with no `gcd_done`, go to RESP with `rsp_result`=0 and `rsp_err`=1.
  - A `gcd_done` in the same cycle as the limit wins: normal result, `rsp_err`=0.
- Undefined: no counter; WAIT blocks indefinitely; `rsp_err` is tied to 0.

## Structure
- Package `gcd_pkg` holds:
  - the state enum `gcd_sched_state_t` (IDLE, LAUNCH, WAIT, RESP);
  - the default `WIDTH` and `TIMEOUT` localparams.
- Sub-module `rr_arbiter` is the combinational round-robin priority pick (inputs `req`, `ptr`; outputs one-hot `grant`, `grant_idx`). It is reusable elsewhere.
- FSM, operand/result registers and the watchdog live in `gcd_sched`.

## Test plan
- Single request: requester 0 sends (48,18) → `gcd_start` one cycle after accept; `rsp_valid[0]` with `rsp_result`=6.
- Contention: all four requesters valid from reset with (12,8), (35,14), (81,27), (17,5):
  - grants in order 0,1,2,3;
  - results 4, 7, 27, 1, each on its own `rsp_valid` bit.
- Rotation: after serving requester 2, requesters 1 and 3 request simultaneously → 3 is granted first, then 1.
- Backpressure: hold `rsp_ready[1]`=0 for 10 cycles → `rsp_valid[1]` and `rsp_result` stay stable, `req_ready` stays 0, and `gcd_start` does not pulse.
- Reset mid-WAIT: assert `reset` during an operation → next cycle all outputs are at reset values, no `rsp_valid`, and the next request goes to requester 0 first.
- With `GCD_SCHED_TIMEOUT_EN` and `TIMEOUT`=16: a gcd model that never asserts `gcd_done` → RESP 16 cycles after entering WAIT, with `rsp_result`=0 and `rsp_err`=1.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and defaults for the gcd_sched round-robin front end.
// The optional watchdog is enabled with `GCD_SCHED_TIMEOUT_EN in gcd_sched.
package gcd_pkg;

    localparam int DEFAULT_WIDTH   = 32;
    localparam int DEFAULT_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } gcd_sched_state_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr,
// wrapping modulo NREQ. Produces a one-hot grant and its binary index.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [2*NREQ-1:0] req_dbl;
    logic [2*NREQ-1:0] req_shift;
    logic [NREQ-1:0]   req_rot;
    logic              any_req;

    // Rotating a doubled copy puts requester ptr at bit 0 of req_rot.
    assign req_dbl   = {req, req};
    assign req_shift = req_dbl >> ptr;
    assign req_rot   = req_shift[NREQ-1:0];
    assign any_req   = |req;

    always_comb begin
        logic found;
        int   sum;
        found     = 1'b0;
        sum       = 0;
        grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_rot[k]) begin
                found = 1'b1;
                sum   = int'(ptr) + k;
                if (sum >= NREQ) begin
                    sum = sum - NREQ;
                end
                grant_idx = IDX_W'(sum);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_grant
            assign grant[gi] = any_req && (grant_idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/gcd_sched.sv
// Round-robin scheduler sharing one gcd unit among NREQ requesters.
// Define GCD_SCHED_TIMEOUT_EN to add a WAIT-state watchdog that returns rsp_err.
module gcd_sched
    import gcd_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  rsp_err,
    output logic                  gcd_start,
    output logic [WIDTH-1:0]      gcd_a,
    output logic [WIDTH-1:0]      gcd_b,
    input  logic                  gcd_done,
    input  logic [WIDTH-1:0]      gcd_result
);

    localparam int IDX_W = idx_width(NREQ);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_LAUNCH = LAUNCH;
    localparam logic [1:0] ST_WAIT   = WAIT;
    localparam logic [1:0] ST_RESP   = RESP;

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [IDX_W-1:0] ptr_reg;
    logic [IDX_W-1:0] ptr_next;
    logic [IDX_W-1:0] grant_idx_reg;
    logic [WIDTH-1:0] gcd_a_reg;
    logic [WIDTH-1:0] gcd_b_reg;
    logic [WIDTH-1:0] rsp_result_reg;

    logic [NREQ-1:0]  arb_grant;
    logic [IDX_W-1:0] arb_idx;
    logic             req_any;
    logic             accept;
    logic             rsp_fire;
    logic             wait_done;
    logic             wd_expire;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] req_a_arr [NREQ];
    logic [WIDTH-1:0] req_b_arr [NREQ];

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_reg),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign req_a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
            assign req_b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
            assign rsp_valid[gi] = (state_reg == ST_RESP) && (grant_idx_reg == IDX_W'(gi));
        end
    endgenerate

    assign sel_a   = req_a_arr[arb_idx];
    assign sel_b   = req_b_arr[arb_idx];
    assign req_any = |req_valid;

    // Gating with reset keeps requesters from seeing an accept that the FSM discards.
    assign accept    = (state_reg == ST_IDLE) && req_any && !reset;
    assign req_ready = accept ? arb_grant : '0;
    assign rsp_fire  = (state_reg == ST_RESP) && rsp_ready[grant_idx_reg];
    assign wait_done = (state_reg == ST_WAIT) && gcd_done;

    assign gcd_start  = (state_reg == ST_LAUNCH);
    assign gcd_a      = gcd_a_reg;
    assign gcd_b      = gcd_b_reg;
    assign rsp_result = rsp_result_reg;

    assign ptr_next = (grant_idx_reg == IDX_W'(NREQ - 1)) ? '0 : grant_idx_reg + 1'b1;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (req_any) state_next = ST_LAUNCH;
            ST_LAUNCH: state_next = ST_WAIT;
            ST_WAIT:   if (gcd_done || wd_expire) state_next = ST_RESP;
            ST_RESP:   if (rsp_fire) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            ptr_reg        <= '0;
            grant_idx_reg  <= '0;
            gcd_a_reg      <= '0;
            gcd_b_reg      <= '0;
            rsp_result_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                gcd_a_reg     <= sel_a;
                gcd_b_reg     <= sel_b;
                grant_idx_reg <= arb_idx;
            end
            // A real result always wins over an expiring watchdog.
            if (wait_done) begin
                rsp_result_reg <= gcd_result;
            end else if (wd_expire) begin
                rsp_result_reg <= '0;
            end
            if (rsp_fire) begin
                ptr_reg <= ptr_next;
            end
        end
    end

`ifdef GCD_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wd_cnt_reg;
    logic             rsp_err_reg;

    // WAIT cycles are counted 0..TIMEOUT-1; the last one without done expires.
    assign wd_expire = (state_reg == ST_WAIT) && !gcd_done
                       && (wd_cnt_reg == CNT_W'(TIMEOUT - 1));
    assign rsp_err   = rsp_err_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_reg  <= '0;
            rsp_err_reg <= 1'b0;
        end else begin
            if (state_reg == ST_LAUNCH) begin
                wd_cnt_reg <= '0;
            end else if (state_reg == ST_WAIT) begin
                wd_cnt_reg <= wd_cnt_reg + 1'b1;
            end
            if (wait_done) begin
                rsp_err_reg <= 1'b0;
            end else if (wd_expire) begin
                rsp_err_reg <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;

    assign wd_expire      = 1'b0;
    assign rsp_err        = 1'b0;
    assign unused_timeout = |TIMEOUT;
`endif

endmodule
